serial_nibble_loader: RTL
=========================

Name: serial_nibble_loader

Overview:
Upstream input stage for the 4-bit D register bank. Deserialises a framed single-bit stream into WIDTH-bit words and presents each completed word on a stable parallel bus that drives the register's D input. Flags framing faults and counts delivered words for debug. Single clock domain, same clk as the register stage.

Parameters:
WIDTH, 4, word width in bits; legal range 2..16; must match the downstream register width.
MSB_FIRST, 1, 1 = first serial bit lands in d_out[WIDTH-1]; 0 = first serial bit lands in d_out[0].
CNT_W, 8, width of the word counter.

Ports:
clk  input  1  rising-edge clock shared with the register stage
rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk
in_valid  input  1  qualifies in_bit/in_sof this cycle
in_bit  input  1  serial data bit
in_sof  input  1  start-of-frame; marks in_bit as the first bit of a word (only meaningful with in_valid)
d_out  output  WIDTH  last completed word; drives register D
d_valid  output  1  one-cycle pulse: d_out updated this cycle
busy  output  1  high while a word is partially assembled
frame_err  output  1  one-cycle pulse on a framing violation
word_cnt  output  CNT_W  number of completed words, modulo 2^CNT_W

Behaviour:
- All outputs registered; no combinational input-to-output paths.
- Reset (rst_n low at a rising edge): state=IDLE, shift reg=0, bit_cnt=0, d_out=0, d_valid=0, busy=0, frame_err=0, word_cnt=0. Reset has priority over all other inputs. Reset mid-word discards the partial word silently, with no frame_err.
- States: IDLE, SHIFT. busy = (state==SHIFT).
- IDLE, in_valid & in_sof: load in_bit as the first bit, bit_cnt=1, go to SHIFT.
- IDLE, in_valid & !in_sof: stray bit. Discard it, pulse frame_err, stay in IDLE.
- IDLE, !in_valid: hold.
- SHIFT, !in_valid: hold all state. There is no timeout; gaps of any length are legal.
- SHIFT, in_valid & !in_sof & bit_cnt<WIDTH-1: shift in_bit in, bit_cnt++.
- SHIFT, in_valid & !in_sof & bit_cnt==WIDTH-1 (last bit):
  - On the same edge, d_out <= complete word, d_valid=1 for exactly one cycle, word_cnt++, state=IDLE, bit_cnt=0.
  - Latency: d_out is valid in the cycle immediately after the edge that samples the last bit.
- SHIFT, in_valid & in_sof: premature start.
  - Pulse frame_err and discard the partial word.
  - Treat in_bit as the first bit of a new word: bit_cnt=1, stay in SHIFT.
  - d_out, d_valid and word_cnt are unaffected.
- Bit ordering:
  - MSB_FIRST=1: shift left, new bit enters at bit 0, so the first bit ends up in d_out[WIDTH-1].
  - MSB_FIRST=0: shift right, new bit enters at bit WIDTH-1, so the first bit ends up in d_out[0].
- d_out holds its value between words. It changes only on word completion or reset, so the downstream register recaptures the same value until the next word.
- word_cnt wraps from 2^CNT_W-1 to 0 with no flag.
- Back-to-back words: a word may complete on edge N and the next word's in_sof may be accepted on edge N+1. No dead cycle is required.
- d_valid and frame_err are never high in the same cycle.
- in_bit and in_sof are don't-care when in_valid is low.

Test Plan:
(WIDTH=4, MSB_FIRST=1 unless stated)
1. Reset: rst_n=0 for 2 edges with random inputs -> d_out=0000, d_valid=0, busy=0, frame_err=0, word_cnt=0.
2. Basic word: bits 1,0,1,0 on consecutive edges, in_sof with the first -> d_out=1010 and d_valid=1 in the cycle after edge 4 only, word_cnt=1, busy high after edges 1-3 then low.
3. Gapped word with back-to-back follow-on:
   - Send 1,1, then in_valid low for 3 cycles, then 1,1 -> d_out stays 1010 through the gap, then becomes 1111, word_cnt=2.
   - Immediately send sof 0,0,1,1 -> d_out=0011, word_cnt=3, no idle cycle needed.
4. Framing errors:
   - sof 0,1 then sof 1,1,0,0 -> frame_err pulses once at the second sof, d_out=1100, word_cnt increments once.
   - Stray in_valid bit with no sof in IDLE -> frame_err pulse, busy stays 0.
5. Reset mid-word: sof 1,0, rst_n low for 1 edge, then sof 0,1,0,1 -> busy=0 after reset, no frame_err, d_out=0101, word_cnt=1.
6. Bit ordering and wrap:
   - MSB_FIRST=0: sof 1,0,0,0 -> d_out=0001.
   - Drive 256 words -> word_cnt returns to 0 after the 256th word, and d_valid pulses exactly 256 times.

Source files
------------

// File: rtl/serial_nibble_loader.sv
// serial_nibble_loader: deserialises a framed single-bit stream into WIDTH-bit
// words and holds the last completed word on a stable parallel bus for the
// downstream D register.
//
// Ports:
//   clk        rising-edge clock shared with the register stage
//   rst_n      synchronous active-low reset
//   in_valid   qualifies in_bit / in_sof this cycle
//   in_bit     serial data bit
//   in_sof     start of frame, marks in_bit as the first bit of a word
//   d_out      last completed word (held between words)
//   d_valid    one-cycle pulse, d_out updated this cycle
//   busy       a word is partially assembled
//   frame_err  one-cycle pulse on a framing violation
//   word_cnt   completed words, modulo 2^CNT_W
module serial_nibble_loader #(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b1,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             in_sof,
    output logic [WIDTH-1:0] d_out,
    output logic             d_valid,
    output logic             busy,
    output logic             frame_err,
    output logic [CNT_W-1:0] word_cnt
);

    // bit_cnt only ever holds 0..WIDTH-1
    localparam int unsigned BC_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam int unsigned SH_W = WIDTH - 1;
    localparam logic [BC_W-1:0] LAST_BIT = BC_W'(WIDTH - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t              r_state;
    // Only WIDTH-1 bits need storing: the last bit goes straight into d_out.
    logic [SH_W-1:0]     r_shift;
    logic [BC_W-1:0]     r_bit_cnt;
    logic [WIDTH-1:0]    r_d_out;
    logic                r_d_valid;
    logic                r_busy;
    logic                r_frame_err;
    logic [CNT_W-1:0]    r_word_cnt;

    state_t              w_state_nxt;
    logic [SH_W-1:0]     w_shift_nxt;
    logic [BC_W-1:0]     w_bit_cnt_nxt;
    logic [WIDTH-1:0]    w_d_out_nxt;
    logic                w_d_valid_nxt;
    logic                w_frame_err_nxt;
    logic [CNT_W-1:0]    w_word_cnt_nxt;

    logic [WIDTH-1:0]    w_word;       // r_shift with in_bit appended
    logic [WIDTH-1:0]    w_word_first; // empty register with in_bit appended
    logic [SH_W-1:0]     w_keep;       // partial word retained after a shift
    logic [SH_W-1:0]     w_keep_first; // partial word after a start-of-frame bit

    // Bit placement: MSB-first shifts left, LSB-first shifts right.
    always_comb begin
        w_word       = '0;
        w_word_first = '0;
        w_keep       = '0;
        w_keep_first = '0;
        if (MSB_FIRST) begin
            w_word       = {r_shift, in_bit};
            w_word_first = {SH_W'(0), in_bit};
            w_keep       = w_word[SH_W-1:0];
            w_keep_first = w_word_first[SH_W-1:0];
        end else begin
            w_word       = {in_bit, r_shift};
            w_word_first = {in_bit, SH_W'(0)};
            w_keep       = w_word[WIDTH-1:1];
            w_keep_first = w_word_first[WIDTH-1:1];
        end
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt     = r_state;
        w_shift_nxt     = r_shift;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_d_out_nxt     = r_d_out;
        w_d_valid_nxt   = 1'b0;
        w_frame_err_nxt = 1'b0;
        w_word_cnt_nxt  = r_word_cnt;

        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    if (in_sof) begin
                        w_shift_nxt   = w_keep_first;
                        w_bit_cnt_nxt = BC_W'(1);
                        w_state_nxt   = ST_SHIFT;
                    end else begin
                        // stray bit outside a frame is dropped
                        w_frame_err_nxt = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                if (in_valid) begin
                    if (in_sof) begin
                        // premature start: abandon partial word, restart
                        w_frame_err_nxt = 1'b1;
                        w_shift_nxt     = w_keep_first;
                        w_bit_cnt_nxt   = BC_W'(1);
                    end else if (r_bit_cnt == LAST_BIT) begin
                        w_d_out_nxt    = w_word;
                        w_d_valid_nxt  = 1'b1;
                        w_word_cnt_nxt = r_word_cnt + CNT_W'(1);
                        w_shift_nxt    = '0;
                        w_bit_cnt_nxt  = '0;
                        w_state_nxt    = ST_IDLE;
                    end else begin
                        w_shift_nxt   = w_keep;
                        w_bit_cnt_nxt = r_bit_cnt + BC_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_d_out     <= '0;
            r_d_valid   <= 1'b0;
            r_busy      <= 1'b0;
            r_frame_err <= 1'b0;
            r_word_cnt  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_shift     <= w_shift_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_d_out     <= w_d_out_nxt;
            r_d_valid   <= w_d_valid_nxt;
            r_busy      <= (w_state_nxt == ST_SHIFT);
            r_frame_err <= w_frame_err_nxt;
            r_word_cnt  <= w_word_cnt_nxt;
        end
    end

    assign d_out     = r_d_out;
    assign d_valid   = r_d_valid;
    assign busy      = r_busy;
    assign frame_err = r_frame_err;
    assign word_cnt  = r_word_cnt;

endmodule
